// File: rtl/gpio_checker.sv
// Checks that a GPIO bus steps through a preloaded sequence of values.
// Only changes of the bus are judged; a run ends in PASS, FAIL (mismatch) or FAIL (timeout).
module gpio_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int TIMEOUT    = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_valid,
   input  logic [DATA_WIDTH-1:0]          load_data,
   input  logic                           start,
   input  logic                           clear,
   input  logic [DATA_WIDTH-1:0]          gpio,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic                           timeout,
   output logic                           overflow,
   output logic [$clog2(DEPTH)-1:0]       err_index,
   output logic [DATA_WIDTH-1:0]          err_value,
   output logic [$clog2(TIMEOUT+1)-1:0]   cycles
);

   localparam int IW   = $clog2(DEPTH);
   localparam int CNTW = IW + 1;
   localparam int CW   = $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] FULL   = CNTW'(DEPTH);
   localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t                state;
   logic [CNTW-1:0]       count;
   logic [IW-1:0]         ptr;
   logic [DATA_WIDTH-1:0] entries [DEPTH];
   logic [DATA_WIDTH-1:0] gpio_prev;

   logic                  load_ok;
   logic                  bus_event;
   logic                  hit;
   logic                  last;
   logic [CW-1:0]         cyc_next;

   always_comb begin
      load_ok   = (state == S_IDLE) && load_valid && (count != FULL);
      bus_event = (gpio != gpio_prev);
      hit       = (gpio == entries[ptr]);
      last      = (({1'b0, ptr} + 1'b1) == count);
      cyc_next  = cycles + 1'b1;
   end

   // Table and previous-bus sample are pure data; gpio_prev only matters in RUN,
   // where its value is always the bus from the cycle before (the start cycle included).
   always_ff @(posedge clk) begin
      if (load_ok)
         entries[count[IW-1:0]] <= load_data;
      gpio_prev <= gpio;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         ptr       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         overflow  <= 1'b0;
         err_index <= '0;
         err_value <= '0;
         cycles    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_valid) begin
                  if (count == FULL)
                     overflow <= 1'b1;
                  else
                     count <= count + 1'b1;
               end
               // A same-cycle load counts towards a non-empty table.
               if (start && ((count != '0) || load_ok)) begin
                  state  <= S_RUN;
                  ptr    <= '0;
                  cycles <= '0;
                  busy   <= 1'b1;
               end
            end
            S_RUN: begin
               cycles <= cyc_next;
               if (bus_event && hit) begin
                  ptr <= ptr + 1'b1;
                  if (last) begin
                     state <= S_PASS;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else if (cyc_next == TO_VAL) begin
                     state     <= S_FAIL;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     timeout   <= 1'b1;
                     err_index <= ptr + 1'b1;
                  end
               end else if (bus_event) begin
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timeout   <= 1'b0;
                  err_index <= ptr;
                  err_value <= gpio;
               end else if (cyc_next == TO_VAL) begin
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timeout   <= 1'b1;
                  err_index <= ptr;
               end
            end
            default: begin
               if (clear) begin
                  state     <= S_IDLE;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  err_index <= '0;
                  err_value <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_checker.sv
// Bench for gpio_checker: directed scenarios with literal checks plus randomized traffic
// compared every cycle against a sequence-level reference model.
module tb_gpio_checker;

   localparam int DW  = 32;
   localparam int DEP = 16;
   localparam int TO  = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] gpio = '0;
   logic          busy, done, pass, timeout, overflow;
   logic [3:0]    err_index;
   logic [DW-1:0] err_value;
   logic [5:0]    cycles;

   gpio_checker #(.DATA_WIDTH(DW), .DEPTH(DEP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .start(start), .clear(clear), .gpio(gpio), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .overflow(overflow), .err_index(err_index),
      .err_value(err_value), .cycles(cycles)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a list of expected values, a position in it, and a run outcome.
   string         m_mode = "idle";
   logic [DW-1:0] m_list [$];
   int            m_pos = 0, m_cyc = 0, m_eidx = 0;
   logic [DW-1:0] m_last_bus = '0, m_eval = '0;
   bit            m_ovf = 0, m_to = 0;

   task automatic model_step();
      if (rst) begin
         m_mode = "idle"; m_list.delete(); m_pos = 0; m_cyc = 0;
         m_ovf = 0; m_to = 0; m_eidx = 0; m_eval = '0;
      end else if (m_mode == "idle") begin
         if (load_valid) begin
            if (m_list.size() < DEP) m_list.push_back(load_data);
            else m_ovf = 1;
         end
         if (start && m_list.size() > 0) begin
            m_mode = "run"; m_pos = 0; m_cyc = 0;
         end
      end else if (m_mode == "run") begin
         m_cyc++;
         if (gpio != m_last_bus) begin
            if (gpio == m_list[m_pos]) begin
               m_pos++;
               if (m_pos == m_list.size()) m_mode = "pass";
            end else begin
               m_mode = "fail"; m_eidx = m_pos; m_eval = gpio; m_to = 0;
            end
         end
         if (m_mode == "run" && m_cyc == TO) begin
            m_mode = "fail"; m_to = 1; m_eidx = m_pos;
         end
      end else if (clear) begin
         m_mode = "idle"; m_to = 0; m_eidx = 0; m_eval = '0;
      end
      m_last_bus = gpio;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         armed = 1;
         @(negedge clk);
         if (armed) begin
            check("busy",      busy,      (m_mode == "run"));
            check("done",      done,      (m_mode == "pass" || m_mode == "fail"));
            check("pass",      pass,      (m_mode == "pass"));
            check("timeout",   timeout,   m_to);
            check("overflow",  overflow,  m_ovf);
            check("err_index", err_index, m_eidx);
            check("err_value", err_value, m_eval);
            check("cycles",    cycles,    m_cyc);
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic do_reset();
      rst = 1; load_valid = 0; start = 0; clear = 0; gpio = '0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic load(input logic [DW-1:0] v);
      load_valid = 1; load_data = v; tick(); load_valid = 0;
   endtask

   task automatic go();
      start = 1; tick(); start = 0;
   endtask

   initial begin
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cycles", cycles, 0);

      // Three-step match sequence
      load(1); load(2); load(3); gpio = 0; go();
      gpio = 1; tick(); gpio = 2; tick(); gpio = 3; tick();
      check("seq_done", done, 1);
      check("seq_pass", pass, 1);
      check("seq_cycles", cycles, 3);
      clear = 1; tick(); clear = 0;
      check("clr_done", done, 0);
      check("clr_cycles_held", cycles, 3);

      // Mismatch at second entry
      do_reset();
      load(1); load(2); gpio = 0; go();
      gpio = 1; tick(); gpio = 5; tick();
      check("mm_done", done, 1);
      check("mm_pass", pass, 0);
      check("mm_err_index", err_index, 1);
      check("mm_err_value", err_value, 5);
      check("mm_timeout", timeout, 0);

      // Timeout with a constant bus
      do_reset();
      load(32'hA); gpio = 0; go();
      repeat (31) tick();
      check("to_still_busy", busy, 1);
      tick();
      check("to_done", done, 1);
      check("to_timeout", timeout, 1);
      check("to_err_index", err_index, 0);
      check("to_cycles", cycles, 32);

      // Final match on the timeout cycle
      do_reset();
      load(7); gpio = 0; go();
      repeat (31) tick();
      gpio = 7; tick();
      check("race_pass", pass, 1);
      check("race_timeout", timeout, 0);
      check("race_cycles", cycles, 32);

      // Table overflow
      do_reset();
      for (int i = 0; i < DEP; i++) load(i + 1);
      check("full_no_ovf", overflow, 0);
      load(99);
      check("ovf_set", overflow, 1);
      clear = 1; tick(); clear = 0;
      check("ovf_after_clear", overflow, 1);
      do_reset();
      check("ovf_after_rst", overflow, 0);

      // Load and start in the same cycle
      gpio = 0; load_valid = 1; load_data = 9; start = 1; tick();
      load_valid = 0; start = 0;
      check("ls_busy", busy, 1);
      gpio = 9; tick();
      check("ls_pass", pass, 1);

      // Reset in the middle of a run
      do_reset();
      load(4); gpio = 0; go(); tick(); tick();
      rst = 1; tick(); rst = 0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cycles", cycles, 0);
      go();
      check("empty_start_ignored", busy, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = $urandom_range(0, 3);
         start      = ($urandom_range(0, 5) == 0);
         clear      = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) gpio = $urandom_range(0, 3);
         tick();
      end
      rst = 0; load_valid = 0; start = 0; clear = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
